// File: rtl/random_stim_harness.sv
// Pseudo-random stimulus harness: NUM_CH Galois LFSR channels drive a DUT,
// a MISR compacts its observation bus, and a two-state FSM bounds each run.

module rsh_lane #(
  parameter int                  W    = 32,
  parameter logic [W-1:0]        POLY = W'(32'h8020_0003),
  parameter logic [W-1:0]        SEED = W'(1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] o_val
);
  logic [W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = SEED;
    end else if (adv) begin
      // An all-zero register would never leave zero, so reload the seed.
      if (val_q == '0) val_d = SEED;
      else             val_d = (val_q >> 1) ^ (val_q[0] ? POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) val_q <= SEED;
    else        val_q <= val_d;
  end

  assign o_val = val_q;
endmodule

module random_stim_harness #(
  parameter int                    NUM_CH     = 4,
  parameter int                    CH_WIDTH   = 32,
  parameter logic [CH_WIDTH-1:0]   CH_POLY    = CH_WIDTH'(32'h8020_0003),
  parameter int                    SEED_BASE  = 3,
  parameter int                    OBS_WIDTH  = 66,
  parameter int                    MISR_WIDTH = 32,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY  = MISR_WIDTH'(32'h8020_0003),
  parameter int                    RUN_LEN    = 1024,
  localparam int                   CNT_W      = $clog2(RUN_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   i_mode,
  input  logic                         i_step,
  input  logic [OBS_WIDTH-1:0]         i_obs,
  output logic [NUM_CH*CH_WIDTH-1:0]   o_stim,
  output logic [MISR_WIDTH-1:0]        o_signature,
  output logic [CNT_W-1:0]             o_count,
  output logic                         o_done
);
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_RESEED = 2'b11;
  localparam int         NCHUNK      = (OBS_WIDTH + MISR_WIDTH - 1) / MISR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

  typedef enum logic {ACTIVE = 1'b0, DONE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [MISR_WIDTH-1:0]   misr_q, misr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    adv, reseed;
  logic [MISR_WIDTH-1:0]   fold;
  logic [NCHUNK*MISR_WIDTH-1:0] obs_pad;
  logic [NUM_CH-1:0][CH_WIDTH-1:0] stim;

  always_comb begin
    obs_pad = '0;
    obs_pad[OBS_WIDTH-1:0] = i_obs;
    fold = '0;
    for (int i = 0; i < NCHUNK; i++) fold ^= obs_pad[i*MISR_WIDTH +: MISR_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    reseed  = (i_mode == MODE_RESEED);
    if (reseed) begin
      state_d = ACTIVE;
      misr_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (i_mode == MODE_RUN || (i_mode == MODE_STEP && i_step)) begin
            adv    = 1'b1;
            misr_d = ((misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0)) ^ fold;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACTIVE;
      misr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CH_WIDTH-1:0] SEED_T = CH_WIDTH'(SEED_BASE + 2*k + 1);
    localparam logic [CH_WIDTH-1:0] SEED   = (SEED_T == '0) ? CH_WIDTH'(1) : SEED_T;
    rsh_lane #(.W(CH_WIDTH), .POLY(CH_POLY), .SEED(SEED)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (reseed),
      .adv   (adv),
      .o_val (stim[k])
    );
  end

  assign o_stim      = stim;
  assign o_signature = misr_q;
  assign o_count     = cnt_q;
  assign o_done      = (state_q == DONE);
endmodule
